interval_timer_arbiter: RTL and testbench
=========================================

// Module: interval_timer_arbiter
// PURPOSE
//  Shares one loadable up-counter (clear/load/count, carry out at all-ones) between two requesters as an interval timer.
//  Each requester asks for an interval and supplies a start value. The block arbitrates round-robin, loads the start value,
//  counts up to all-ones, then pulses done to the winner.
//  Sits between the counter datapath and the control logic that needs timed waits.
// PARAMETERS
//  WIDTH      4   counter/start-value width; all-ones terminal value = 2**WIDTH-1
//  FIRST_PRIO 0   requester favoured by the round-robin pointer after reset (0 or 1)
// PORTS
//  CLK        in   1      clock, positive-edge
//  Clear_b    in   1      reset, asynchronous, active-low
//  req        in   2      level request per requester; held until done or abort
//  start0     in   WIDTH  start value for requester 0, sampled in LOAD
//  start1     in   WIDTH  start value for requester 1, sampled in LOAD
//  tick_en    in   1      count enable; low pauses the interval
//  grant      out  2      one-hot owner of the counter; 00 when idle
//  busy       out  1      high in LOAD/RUN/DONE
//  done       out  2      one-cycle pulse to the owner on interval expiry
//  cnt_value  out  WIDTH  live counter value, for debug
// BEHAVIOUR
//  Reset: state IDLE, grant=00, done=00, busy=0, cnt_value=0, pointer=FIRST_PRIO; reset is effective immediately, mid-interval included.
//  FSM IDLE->LOAD->RUN->DONE->IDLE:
//   IDLE: if req!=00, pick the winner; only one set -> that one; both set -> pointer holder. Latch the winner; go to LOAD.
//   LOAD: grant=winner one-hot, busy=1; counter load=1 with start of the winner -> cnt_value=start next edge; go to RUN.
//   RUN: counter count=tick_en, load=0. Carry=tick_en && cnt_value==all-ones.
//        On carry, the counter wraps to 0 and the FSM goes to DONE.
//        With tick_en held high, RUN lasts exactly 2**WIDTH-start cycles (start=15 -> 1, start=0 -> 16).
//   DONE: done[winner]=1 for this cycle only; grant stays set; pointer moves to the other requester; next state IDLE.
//  Request-to-grant latency is 1 cycle. Grant changes only on IDLE->LOAD and DONE->IDLE (and on abort).
//  Abort: req[winner] low in LOAD or RUN -> IDLE next cycle. No done pulse; counter holds its value; pointer moves to the other requester.
//  The non-owner's req and start are ignored until IDLE. Back-to-back: a req still high in DONE is re-arbitrated in IDLE the next cycle.
//  Counter width: unsigned WIDTH bits; no saturation; the wrap only ever occurs at carry.
//  tick_en low in LOAD has no effect, because the load always happens.
// CONFIGURATION
//  AUTO_RELOAD_EN defined: in DONE, if req[winner] is still high and the other req is low,
//   go to LOAD for the same winner. The interval repeats without releasing grant, and done pulses each period.
//   The pointer still moves, so a pending other requester wins next.
//  AUTO_RELOAD_EN undefined: DONE always returns to IDLE and grant drops for at least one cycle.
// STRUCTURE
//  Shared package interval_timer_pkg: state enum (IDLE, LOAD, RUN, DONE); requester-index typedef;
//   constant ALL_ONES = {WIDTH{1'b1}}.
//  One sub-module, timer_counter: WIDTH-bit up-counter with async active-low clear, load priority over count,
//   and a carry output. The FSM and arbiter stay in this module.
// TESTING
//  1 Reset: Clear_b=0 mid-RUN at cnt_value=7 -> grant=00, busy=0, done=00, cnt_value=0 at once; IDLE after release.
//  2 Single: req=01, start0=12, tick_en=1 -> grant=01 next cycle; cnt 12,13,14,15,0; done=01 one cycle after carry; 4 RUN cycles.
//  3 Contention: req=11 from reset (FIRST_PRIO=0) -> requester 0 served first; with req=11 held, requester 1 granted after DONE+IDLE.
//  4 Pause: start1=14, tick_en low 3 cycles at cnt=15 -> cnt holds 15 and no done; done follows the first tick after tick_en returns.
//  5 Abort: req=01, start0=0; drop req0 at cnt=5 -> IDLE next cycle, done stays 00, cnt_value holds 5, pointer=1.
//  6 Boundary: start=15 -> single RUN cycle then done. With AUTO_RELOAD_EN, req=01 held -> done every 3 cycles, grant never drops.

Source files
------------

// File: rtl/interval_timer_arbiter_pkg.sv
// Shared types and constants for the interval timer arbiter.
// Holds the FSM state encoding, the requester-index type and the
// default-width all-ones terminal count.
package interval_timer_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam logic [DEF_WIDTH-1:0] ALL_ONES = {DEF_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Index of one of the two requesters.
  typedef logic req_idx_t;

  // One-hot encoding of a requester index, as driven on grant/done.
  function automatic logic [1:0] idx_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/interval_timer_arbiter_if.sv
// Request/grant bundle between the timed-wait control logic (master)
// and the interval timer arbiter (slave).
interface interval_timer_arbiter_if
  import interval_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic [1:0]       req;
  logic [WIDTH-1:0] start0;
  logic [WIDTH-1:0] start1;
  logic             tick_en;
  logic [1:0]       grant;
  logic             busy;
  logic [1:0]       done;
  logic [WIDTH-1:0] cnt_value;

  modport master (
    output req, start0, start1, tick_en,
    input  grant, busy, done, cnt_value
  );

  modport slave (
    input  req, start0, start1, tick_en,
    output grant, busy, done, cnt_value
  );
endinterface

// File: rtl/interval_timer_arbiter_counter.sv
// timer_counter: WIDTH-bit loadable up-counter with async active-low clear.
// Load has priority over count; carry flags a counting step at all-ones,
// on which the counter wraps to zero.
module timer_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_count,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_carry
);

  logic [WIDTH-1:0] r_q;

  // Counter register: clear, load, or increment.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_count) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q     = r_q;
  assign o_carry = i_count && (r_q == {WIDTH{1'b1}});

endmodule

// File: rtl/interval_timer_arbiter.sv
// interval_timer_arbiter: round-robin sharing of one interval counter
// between two requesters. IDLE picks a winner, LOAD loads its start value,
// RUN counts up to all-ones, DONE pulses done to the winner.
// Optional feature macro: AUTO_RELOAD_EN (DONE reloads for the same winner
// while it alone keeps requesting).
module interval_timer_arbiter
  import interval_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned FIRST_PRIO = 0
) (
  input  logic                     CLK,
  input  logic                     Clear_b,
  interval_timer_arbiter_if.slave  if_bus
);

  state_t           r_state;
  req_idx_t         r_winner;
  req_idx_t         r_ptr;
  logic [1:0]       r_grant;
  logic [1:0]       r_done;
  logic             r_busy;

  req_idx_t         w_pick;
  logic             w_winner_req;
  logic             w_load;
  logic             w_count;
  logic             w_carry;
  logic [WIDTH-1:0] w_start;
  logic [WIDTH-1:0] w_cnt;

  // Winner selection: a lone requester wins, contention goes to the pointer.
  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would infer a latch.
  always_comb begin
    w_pick = r_ptr;
    case (if_bus.req)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      default: w_pick = r_ptr;
    endcase
  end

  // A dropped owner request freezes the counter, so an abort holds its value.
  assign w_winner_req = if_bus.req[r_winner];
  assign w_load       = (r_state == LOAD) && w_winner_req;
  assign w_count      = (r_state == RUN) && w_winner_req && if_bus.tick_en;
  assign w_start      = r_winner ? if_bus.start1 : if_bus.start0;

  timer_counter #(.WIDTH(WIDTH)) u_counter (
    .i_clk   (CLK),
    .i_rst_n (Clear_b),
    .i_load  (w_load),
    .i_count (w_count),
    .i_d     (w_start),
    .o_q     (w_cnt),
    .o_carry (w_carry)
  );

  // Control FSM and round-robin pointer, with registered grant/busy/done.
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      r_state  <= IDLE;
      r_winner <= 1'b0;
      r_ptr    <= FIRST_PRIO[0];
      r_grant  <= 2'b00;
      r_done   <= 2'b00;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        IDLE: begin
          if (if_bus.req != 2'b00) begin
            r_winner <= w_pick;
            r_grant  <= idx_onehot(w_pick);
            r_busy   <= 1'b1;
            r_state  <= LOAD;
          end
        end
        LOAD, RUN: begin
          if (!w_winner_req) begin
            r_ptr   <= ~r_winner;
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_state == LOAD) begin
            r_state <= RUN;
          end else if (w_carry) begin
            r_done  <= idx_onehot(r_winner);
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ptr <= ~r_winner;
`ifdef AUTO_RELOAD_EN
          if (w_winner_req && !if_bus.req[~r_winner]) begin
            r_state <= LOAD;
          end else begin
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
`else
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_bus.grant     = r_grant;
  assign if_bus.busy      = r_busy;
  assign if_bus.done      = r_done;
  assign if_bus.cnt_value = w_cnt;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed testbench for interval_timer_arbiter (WIDTH=4, FIRST_PRIO=0).
// Honours AUTO_RELOAD_EN in the boundary scenario.
module tb_interval_timer_arbiter;
  import interval_timer_pkg::*;

  logic CLK = 1'b0;
  logic Clear_b;
  int   n_vec = 0;
  int   n_err = 0;

  interval_timer_arbiter_if #(.WIDTH(4)) bus ();

  interval_timer_arbiter #(.WIDTH(4), .FIRST_PRIO(0)) dut (
    .CLK     (CLK),
    .Clear_b (Clear_b),
    .if_bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Clear_b = 1'b0; bus.req = 2'b00; bus.start0 = '0; bus.start1 = '0; bus.tick_en = 1'b0;
    tick(); tick();
    n_vec++; if (bus.grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b want 00", bus.done); end
    n_vec++; if (bus.cnt_value !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.cnt_value); end
    Clear_b = 1'b1;
    tick();
    n_vec++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: got grant=%b busy=%b want 00/0", bus.grant, bus.busy); end
  endtask

  task automatic test_single();
    logic [3:0] exp_cnt [5];
    logic [1:0] exp_done [5];
    exp_cnt  = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
    exp_done = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    bus.req = 2'b01; bus.start0 = 4'd12; bus.tick_en = 1'b1;
    tick();
    n_vec++; if (bus.grant !== 2'b01 || bus.busy !== 1'b1) begin n_err++; $display("FAIL single_grant: got grant=%b busy=%b want 01/1", bus.grant, bus.busy); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (bus.cnt_value !== exp_cnt[i] || bus.done !== exp_done[i]) begin
        n_err++; $display("FAIL single_run[%0d]: got cnt=%0d done=%b want %0d/%b", i, bus.cnt_value, bus.done, exp_cnt[i], exp_done[i]);
      end
    end
    bus.req = 2'b00;
    tick();
    n_vec++; if (bus.grant !== 2'b00 || bus.done !== 2'b00 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL single_release: got grant=%b done=%b busy=%b want 00/00/0", bus.grant, bus.done, bus.busy);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_grant [10];
    logic [1:0] exp_done [10];
    exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    exp_done  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    Clear_b = 1'b0;
    tick();
    Clear_b = 1'b1;
    bus.req = 2'b11; bus.start0 = 4'd14; bus.start1 = 4'd13; bus.tick_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++; if (bus.grant !== exp_grant[i] || bus.done !== exp_done[i]) begin
        n_err++; $display("FAIL contention[%0d]: got grant=%b done=%b want %b/%b", i, bus.grant, bus.done, exp_grant[i], exp_done[i]);
      end
    end
    bus.req = 2'b00;
    tick();
    n_vec++; if (bus.grant !== 2'b00) begin n_err++; $display("FAIL contention_release: got %b want 00", bus.grant); end
  endtask

  task automatic test_pause();
    bus.req = 2'b10; bus.start1 = 4'd14; bus.tick_en = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (bus.cnt_value !== 4'd15 || bus.grant !== 2'b10) begin
      n_err++; $display("FAIL pause_pre: got cnt=%0d grant=%b want 15/10", bus.cnt_value, bus.grant);
    end
    bus.tick_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (bus.cnt_value !== 4'd15 || bus.done !== 2'b00 || bus.busy !== 1'b1) begin
        n_err++; $display("FAIL pause_hold[%0d]: got cnt=%0d done=%b busy=%b want 15/00/1", i, bus.cnt_value, bus.done, bus.busy);
      end
    end
    bus.tick_en = 1'b1;
    tick();
    n_vec++; if (bus.done !== 2'b10 || bus.cnt_value !== 4'd0) begin
      n_err++; $display("FAIL pause_done: got done=%b cnt=%0d want 10/0", bus.done, bus.cnt_value);
    end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_abort();
    bus.req = 2'b01; bus.start0 = 4'd0; bus.tick_en = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (bus.cnt_value !== 4'd5) begin n_err++; $display("FAIL abort_pre: got cnt=%0d want 5", bus.cnt_value); end
    bus.req = 2'b00;
    tick();
    n_vec++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 2'b00 || bus.cnt_value !== 4'd5) begin
      n_err++; $display("FAIL abort_idle: got grant=%b busy=%b done=%b cnt=%0d want 00/0/00/5", bus.grant, bus.busy, bus.done, bus.cnt_value);
    end
    tick();
    n_vec++; if (bus.cnt_value !== 4'd5 || bus.done !== 2'b00) begin
      n_err++; $display("FAIL abort_hold: got cnt=%0d done=%b want 5/00", bus.cnt_value, bus.done);
    end
    bus.req = 2'b11;
    tick();
    n_vec++; if (bus.grant !== 2'b10) begin n_err++; $display("FAIL abort_pointer: got grant=%b want 10", bus.grant); end
    bus.req = 2'b00;
    tick();
    n_vec++; if (bus.grant !== 2'b00 || bus.cnt_value !== 4'd5) begin
      n_err++; $display("FAIL abort_load: got grant=%b cnt=%0d want 00/5", bus.grant, bus.cnt_value);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.req = 2'b01; bus.start0 = 4'd3; bus.tick_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_vec++; if (bus.cnt_value !== 4'd7 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL midreset_pre: got cnt=%0d busy=%b want 7/1", bus.cnt_value, bus.busy);
    end
    #2 Clear_b = 1'b0;
    #1;
    n_vec++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 2'b00 || bus.cnt_value !== 4'd0) begin
      n_err++; $display("FAIL midreset_async: got grant=%b busy=%b done=%b cnt=%0d want 00/0/00/0", bus.grant, bus.busy, bus.done, bus.cnt_value);
    end
    bus.req = 2'b00;
    tick();
    Clear_b = 1'b1;
    tick();
    n_vec++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.cnt_value !== 4'd0) begin
      n_err++; $display("FAIL midreset_idle: got grant=%b busy=%b cnt=%0d want 00/0/0", bus.grant, bus.busy, bus.cnt_value);
    end
    bus.req = 2'b11;
    tick();
    n_vec++; if (bus.grant !== 2'b01) begin n_err++; $display("FAIL midreset_pointer: got grant=%b want 01", bus.grant); end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_boundary();
    logic [1:0] exp_grant [6];
    logic [1:0] exp_done [6];
    logic [3:0] exp_cnt [6];
`ifdef AUTO_RELOAD_EN
    exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    exp_done  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    exp_cnt   = '{4'd0, 4'd15, 4'd0, 4'd0, 4'd15, 4'd0};
`else
    exp_grant = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
    exp_done  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    exp_cnt   = '{4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 4'd0};
`endif
    bus.req = 2'b01; bus.start0 = 4'd15; bus.tick_en = 1'b1;
    tick();
    n_vec++; if (bus.grant !== 2'b01) begin n_err++; $display("FAIL boundary_grant: got %b want 01", bus.grant); end
    tick();
    n_vec++; if (bus.cnt_value !== 4'd15 || bus.done !== 2'b00) begin
      n_err++; $display("FAIL boundary_run: got cnt=%0d done=%b want 15/00", bus.cnt_value, bus.done);
    end
    tick();
    n_vec++; if (bus.done !== 2'b01 || bus.cnt_value !== 4'd0) begin
      n_err++; $display("FAIL boundary_done: got done=%b cnt=%0d want 01/0", bus.done, bus.cnt_value);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++; if (bus.grant !== exp_grant[i] || bus.done !== exp_done[i] || bus.cnt_value !== exp_cnt[i]) begin
        n_err++; $display("FAIL boundary_repeat[%0d]: got grant=%b done=%b cnt=%0d want %b/%b/%0d",
                          i, bus.grant, bus.done, bus.cnt_value, exp_grant[i], exp_done[i], exp_cnt[i]);
      end
    end
    bus.req = 2'b00;
    tick();
    n_vec++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL boundary_release: got grant=%b busy=%b want 00/0", bus.grant, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_pause();
    test_abort();
    test_reset_mid_run();
    test_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
